// File: rtl/result_receive.sv
// Purpose: collects a signed decimal frame from a UART byte stream and shows it on a 4-digit scrolling window.
// Latency: a terminator byte commits or rejects on the edge it is sampled; outputs and the done pulse appear the next cycle.
// Backpressure: none; one byte is taken per rising edge of rxdDataReady, and bytes arriving while clear is high are dropped.
module result_receive #(
    parameter int SCROLL_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxdData,
    input  logic       rxdDataReady,
    input  logic       clear,
    output logic [3:0] n,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] blank,
    output logic       neg,
    output logic       err,
    output logic       done
);

    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Byte strobe and classification
    logic       rdy_q;
    logic       byte_stb;
    logic       is_digit;
    logic       is_minus;
    logic       is_term;
    logic [3:0] digit;

    // Collector state: positions 1..8 packed MSB-first, position 8 in bits [3:0]
    logic [3:0]  cnt;
    logic [31:0] shf;
    logic        pend_neg;

    // FSM decode strobes
    logic do_load;
    logic do_minus;
    logic do_shift;
    logic do_commit;
    logic do_reject;

    // Display state
    logic [31:0]      res;
    logic [3:0]       s_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       first_pos;

    // Select display position p (1..8) out of the packed result word.
    function automatic logic [3:0] pick(input logic [31:0] v, input logic [3:0] p);
        logic [3:0] r;
        case (p)
            4'd1:    r = v[31:28];
            4'd2:    r = v[27:24];
            4'd3:    r = v[23:20];
            4'd4:    r = v[19:16];
            4'd5:    r = v[15:12];
            4'd6:    r = v[11:8];
            4'd7:    r = v[7:4];
            4'd8:    r = v[3:0];
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // A held-high ready level counts once; clear swallows any byte edge it coincides with.
    assign byte_stb = rxdDataReady & ~rdy_q & ~clear;
    assign is_digit = (rxdData >= 8'h30) && (rxdData <= 8'h39);
    assign is_minus = (rxdData == 8'h2D);
    assign is_term  = (rxdData == 8'h0A) || (rxdData == 8'h0D);
    assign digit    = rxdData[3:0];

    // Edge-detect register follows the ready level even during clear so a held byte is not replayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rxdDataReady;
        end
    end

    // Collector state register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-byte action decode.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_minus  = 1'b0;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        do_reject = 1'b0;
        if (byte_stb) begin
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        do_load   = 1'b1;
                        state_nxt = RECV;
                    end else if (is_minus) begin
                        do_minus  = 1'b1;
                        state_nxt = RECV;
                    end else if (!is_term) begin
                        // Stray terminators between frames are harmless and ignored.
                        state_nxt = DISCARD;
                    end
                end
                RECV: begin
                    if (is_digit && (cnt < 4'd8)) begin
                        do_shift = 1'b1;
                    end else if (is_term) begin
                        if (cnt != 4'd0) begin
                            do_commit = 1'b1;
                        end else begin
                            do_reject = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        do_reject = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Digit shifter: new digits enter at position 8 and older ones move toward position 1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt      <= 4'd0;
            shf      <= 32'd0;
            pend_neg <= 1'b0;
        end else if (do_load) begin
            cnt      <= 4'd1;
            shf      <= {28'd0, digit};
            pend_neg <= 1'b0;
        end else if (do_minus) begin
            cnt      <= 4'd0;
            shf      <= 32'd0;
            pend_neg <= 1'b1;
        end else if (do_shift) begin
            cnt      <= cnt + 4'd1;
            shf      <= {shf[27:0], digit};
        end else if (do_commit || do_reject) begin
            cnt      <= 4'd0;
            shf      <= 32'd0;
            pend_neg <= 1'b0;
        end
    end

    // Result registers and scroll position; a frame end takes priority over a scroll step.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            res   <= 32'd0;
            n     <= 4'd0;
            neg   <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b0;
            s_q   <= 4'd5;
            div_q <= '0;
        end else begin
            done <= do_commit | do_reject;
            if (do_commit) begin
                res   <= shf;
                n     <= cnt;
                neg   <= pend_neg;
                err   <= 1'b0;
                s_q   <= (cnt > 4'd4) ? (4'd9 - cnt) : 4'd5;
                div_q <= '0;
            end else if (do_reject) begin
                res   <= 32'd0;
                n     <= 4'd0;
                neg   <= 1'b0;
                err   <= 1'b1;
                s_q   <= 4'd5;
                div_q <= '0;
            end else if (n > 4'd4) begin
                if (div_q == DIV_LAST) begin
                    div_q <= '0;
                    s_q   <= (s_q == 4'd5) ? (4'd9 - n) : (s_q + 4'd1);
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    // Window decode straight from the result and scroll registers; positions left of the number are blanked.
    always_comb begin
        first_pos = 4'd9 - n;
        num1      = pick(res, s_q);
        num2      = pick(res, s_q + 4'd1);
        num3      = pick(res, s_q + 4'd2);
        num4      = pick(res, s_q + 4'd3);
        blank[3]  = (s_q < first_pos);
        blank[2]  = ((s_q + 4'd1) < first_pos);
        blank[1]  = ((s_q + 4'd2) < first_pos);
        blank[0]  = ((s_q + 4'd3) < first_pos);
    end

endmodule

// File: tb/tb_result_receive.sv
// Purpose: self-checking bench for result_receive with a frame-result scoreboard popped on every done pulse.
// Latency: results are compared on the negedge of the done cycle; scroll windows are compared cycle by cycle.
// Backpressure: none; bytes are driven as ready-level pulses with a low gap between them.
module tb_result_receive;

    localparam int DIV = 2;

    logic       clk;
    logic       reset;
    logic [7:0] rxdData;
    logic       rxdDataReady;
    logic       clear;
    logic [3:0] n;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic [3:0] blank;
    logic       neg;
    logic       err;
    logic       done;

    typedef struct packed {
        logic [3:0]  n;
        logic        neg;
        logic        err;
        logic [15:0] nums;
        logic [3:0]  blank;
    } exp_t;

    exp_t sb[$];
    int   passed;
    int   total;
    int   done_cnt;

    result_receive #(.SCROLL_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .rxdData      (rxdData),
        .rxdDataReady (rxdDataReady),
        .clear        (clear),
        .n            (n),
        .num1         (num1),
        .num2         (num2),
        .num3         (num3),
        .num4         (num4),
        .blank        (blank),
        .neg          (neg),
        .err          (err),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] en, input logic eneg, input logic eerr,
                            input logic [15:0] enums, input logic [3:0] eblank);
        exp_t e;
        e.n     = en;
        e.neg   = eneg;
        e.err   = eerr;
        e.nums  = enums;
        e.blank = eblank;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    task automatic monitor();
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (!reset && done === 1'b1) begin
                done_cnt++;
                got = {n, neg, err, num1, num2, num3, num4, blank};
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL done_unexpected: got result %h, required no done pulse", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        $display("FAIL frame_result: got n/neg/err/nums/blank %h, required %h", got, e);
                    end else begin
                        passed++;
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; leaves the bus idle one cycle after the byte.
    task automatic send_byte(input logic [7:0] b, input int hold);
        rxdData      = b;
        rxdDataReady = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rxdDataReady = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string str);
        for (int i = 0; i < str.len(); i++) begin
            send_byte(str[i], 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({n, neg, err, done, num1, num2, num3, num4, blank} !== {4'd0, 3'b000, 16'h0000, 4'b1111}) begin
            $display("FAIL reset_values: got %h, required %h",
                     {n, neg, err, done, num1, num2, num3, num4, blank}, {4'd0, 3'b000, 16'h0000, 4'b1111});
        end else begin
            passed++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_negative();
        int d0;
        d0 = done_cnt;
        push_exp(4'd3, 1'b1, 1'b0, 16'h0123, 4'b1000);
        send_str("-123\n");
        total++;
        if (done_cnt - d0 !== 1) begin
            $display("FAIL neg_done_count: got %0d, required 1", done_cnt - d0);
        end else begin
            passed++;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({num1, num2, num3, num4, blank, done} !== {16'h0123, 4'b1000, 1'b0}) begin
                $display("FAIL neg_static_window: got %h, required %h",
                         {num1, num2, num3, num4, blank, done}, {16'h0123, 4'b1000, 1'b0});
            end else begin
                passed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_scroll();
        int sv;
        logic [15:0] ew;
        push_exp(4'd8, 1'b0, 1'b0, 16'h1234, 4'b0000);
        send_str("12345678");
        rxdData      = 8'h0D;
        rxdDataReady = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rxdDataReady = 1'b0;
            sv = 1 + ((k / DIV) % 5);
            ew = {4'(sv), 4'(sv + 1), 4'(sv + 2), 4'(sv + 3)};
            total++;
            if ({num1, num2, num3, num4, blank} !== {ew, 4'b0000}) begin
                $display("FAIL scroll_window k=%0d: got %h, required %h", k,
                         {num1, num2, num3, num4, blank}, {ew, 4'b0000});
            end else begin
                passed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int d0;
        d0 = done_cnt;
        push_exp(4'd0, 1'b0, 1'b1, 16'h0000, 4'b1111);
        send_str("1234");
        total++;
        if ({n, err} !== {4'd8, 1'b0}) begin
            $display("FAIL hold_during_collect: got n/err %h, required %h", {n, err}, {4'd8, 1'b0});
        end else begin
            passed++;
        end
        send_str("56789\n");
        total++;
        if (done_cnt - d0 !== 1) begin
            $display("FAIL overflow_done_count: got %0d, required 1", done_cnt - d0);
        end else begin
            passed++;
        end
    endtask

    task automatic test_held_level();
        int d0;
        d0 = done_cnt;
        push_exp(4'd1, 1'b0, 1'b0, 16'h0005, 4'b1110);
        send_byte(8'h35, 10);
        send_str("\n");
        total++;
        if (done_cnt - d0 !== 1) begin
            $display("FAIL held_done_count: got %0d, required 1", done_cnt - d0);
        end else begin
            passed++;
        end
    endtask

    task automatic test_bad_char();
        int d0;
        d0 = done_cnt;
        push_exp(4'd0, 1'b0, 1'b1, 16'h0000, 4'b1111);
        send_str("1A2\n");
        push_exp(4'd1, 1'b0, 1'b0, 16'h0007, 4'b1110);
        send_str("7\n");
        total++;
        if (done_cnt - d0 !== 2) begin
            $display("FAIL badchar_done_count: got %0d, required 2", done_cnt - d0);
        end else begin
            passed++;
        end
    endtask

    task automatic test_clear();
        int d0;
        push_exp(4'd2, 1'b1, 1'b0, 16'h0042, 4'b1100);
        send_str("-42\n");
        send_str("9");
        d0 = done_cnt;
        rxdData      = 8'h38;
        rxdDataReady = 1'b1;
        clear        = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        total++;
        if ({n, neg, err, done, num1, num2, num3, num4, blank} !== {4'd0, 3'b000, 16'h0000, 4'b1111}) begin
            $display("FAIL clear_values: got %h, required %h",
                     {n, neg, err, done, num1, num2, num3, num4, blank}, {4'd0, 3'b000, 16'h0000, 4'b1111});
        end else begin
            passed++;
        end
        repeat (2) @(posedge clk);
        #1 rxdDataReady = 1'b0;
        @(posedge clk);
        #1;
        send_str("\n");
        total++;
        if (done_cnt - d0 !== 0) begin
            $display("FAIL clear_no_done: got %0d pulses, required 0", done_cnt - d0);
        end else begin
            passed++;
        end
        push_exp(4'd1, 1'b0, 1'b0, 16'h0003, 4'b1110);
        send_str("3\n");
        push_exp(4'd0, 1'b0, 1'b1, 16'h0000, 4'b1111);
        send_str("Q\n");
        d0 = done_cnt;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        total++;
        if ({err, done, n} !== {1'b0, 1'b0, 4'd0}) begin
            $display("FAIL clear_err: got err/done/n %h, required %h", {err, done, n}, {1'b0, 1'b0, 4'd0});
        end else begin
            passed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        send_str("12");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        push_exp(4'd1, 1'b0, 1'b0, 16'h0007, 4'b1110);
        send_str("7\n");
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        send_str("\r");
        total++;
        if (done_cnt - d0 !== 0) begin
            $display("FAIL idle_terminator: got %0d pulses, required 0", done_cnt - d0);
        end else begin
            passed++;
        end
        push_exp(4'd1, 1'b0, 1'b0, 16'h0005, 4'b1110);
        push_exp(4'd1, 1'b1, 1'b0, 16'h0006, 4'b1110);
        push_exp(4'd5, 1'b0, 1'b0, 16'h9876, 4'b0000);
        send_str("5\n-6\n98765\n");
        total++;
        if (done_cnt - d0 !== 3) begin
            $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - d0);
        end else begin
            passed++;
        end
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        done_cnt     = 0;
        reset        = 1'b1;
        clear        = 1'b0;
        rxdData      = 8'h00;
        rxdDataReady = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_negative();
        test_scroll();
        test_overflow();
        test_held_level();
        test_bad_char();
        test_clear();
        test_reset_midframe();
        test_back_to_back();
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() !== 0) begin
            $display("FAIL results_missing: got %0d outstanding, required 0", sb.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
